// File: rtl/fifo_wm.sv
// Parametrised flip-flop FIFO with first-word-fall-through output, watermark flag, sticky error flags and drop counter.
// Define FIFO_TEST_PATTERN_EN to replace write data with self-tagged test words when test_mode is high.
module fifo_wm #(
    parameter int FIFO_WIDTH    = 63,
    parameter int FIFO_DEPTH    = 256,
    parameter int FIFO_BITS     = 8,
    parameter int DROP_CNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [FIFO_WIDTH-1:0]    data_in,
    input  logic                     write_n,
    input  logic                     read_n,
    input  logic [FIFO_BITS:0]       high_watermark,
    input  logic                     clear_flags,
    input  logic                     test_mode,
    input  logic [7:0]               chip_id,
    input  logic [31:0]              timestamp_32b,
    output logic [FIFO_WIDTH-1:0]    data_out,
    output logic [FIFO_BITS:0]       fifo_counter,
    output logic                     fifo_full,
    output logic                     fifo_half,
    output logic                     fifo_high,
    output logic                     fifo_empty,
    output logic                     overflow,
    output logic                     underflow,
    output logic [DROP_CNT_BITS-1:0] drop_count
);

    localparam logic [FIFO_BITS:0]       DEPTH_CNT = (FIFO_BITS+1)'(FIFO_DEPTH);
    localparam logic [FIFO_BITS:0]       HALF_CNT  = (FIFO_BITS+1)'(FIFO_DEPTH / 2);
    localparam logic [FIFO_BITS:0]       CNT_ONE   = (FIFO_BITS+1)'(1);
    localparam logic [FIFO_BITS-1:0]     PTR_ONE   = FIFO_BITS'(1);
    localparam logic [DROP_CNT_BITS-1:0] DROP_ONE  = DROP_CNT_BITS'(1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_BITS-1:0]  wr_ptr;
    logic [FIFO_BITS-1:0]  rd_ptr;
    logic [FIFO_BITS:0]    count;
    logic [FIFO_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  empty;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  drop;
    logic                  rd_empty;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign rd_ok    = !read_n && !empty;
    // A full FIFO still takes a write when the same edge frees a slot.
    assign wr_ok    = !write_n && (!full || rd_ok);
    assign drop     = !write_n && full && !rd_ok;
    assign rd_empty = !read_n && empty;

`ifdef FIFO_TEST_PATTERN_EN
    logic [15:0] seq_cnt;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        wr_data = data_in;
        if (test_mode) begin
            wr_data       = '0;
            wr_data[55:0] = {seq_cnt, timestamp_32b, chip_id};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seq_cnt <= '0;
        end else if (wr_ok && test_mode) begin
            seq_cnt <= seq_cnt + 16'd1;
        end
    end
`else
    logic unused_test_inputs;

    assign wr_data            = data_in;
    assign unused_test_inputs = ^{test_mode, chip_id, timestamp_32b};
`endif

    // NOTE: storage has no reset; pointers and count define validity, and reset only blocks the write.
    always_ff @(posedge clk) begin
        if (reset_n && wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CNT_ONE;
            end else if (rd_ok && !wr_ok) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // A same-cycle event overrides clear_flags, so the drop counter restarts at one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (clear_flags) begin
                overflow   <= 1'b0;
                underflow  <= 1'b0;
                drop_count <= '0;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (clear_flags) begin
                    drop_count <= DROP_ONE;
                end else if (!(&drop_count)) begin
                    drop_count <= drop_count + DROP_ONE;
                end
            end
            if (rd_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign fifo_counter = count;
    assign fifo_full    = full;
    assign fifo_half    = (count >= HALF_CNT);
    assign fifo_high    = (count >= high_watermark);
    assign fifo_empty   = empty;
    assign data_out     = empty ? '0 : mem[rd_ptr];

endmodule

// File: doc/fifo_wm.md
Name: fifo_wm

Overview:
- Parametrised synchronous FIFO for buffering event words before they are processed or sent off chip.
- Successor to the fixed-configuration FIFO top: depth and width are generic, and it adds:
  - a programmable high-watermark flag
  - sticky overflow/underflow flags
  - a saturating dropped-word counter
  - an optional test-pattern generator for self-tagged data.
- Sits between event builder (writer) and serializer/readout (reader).
- Storage is flip-flop based; output is first-word-fall-through (FWFT).

Parameters:
- FIFO_WIDTH, 63, width of each stored word (parity not stored); must be >= 56 when FIFO_TEST_PATTERN_EN is defined.
- FIFO_DEPTH, 256, number of words; power of two, >= 4.
- FIFO_BITS, 8, log2(FIFO_DEPTH); pointer width.
- DROP_CNT_BITS, 16, width of saturating dropped-word counter.

Ports:
- clk  input  1  master clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low digital reset.
- data_in  input  FIFO_WIDTH  write data.
- write_n  input  1  write request (active low).
- read_n  input  1  read/pop request (active low).
- high_watermark  input  FIFO_BITS+1  threshold for fifo_high; quasi-static.
- clear_flags  input  1  synchronous clear of sticky flags and drop counter (active high).
- test_mode  input  1  select test-pattern write data (used only with FIFO_TEST_PATTERN_EN).
- chip_id  input  8  chip ID for test-pattern tagging.
- timestamp_32b  input  32  timestamp for test-pattern tagging.
- data_out  output  FIFO_WIDTH  head-of-FIFO word (FWFT); all zeros when empty.
- fifo_counter  output  FIFO_BITS+1  words currently stored (0..FIFO_DEPTH).
- fifo_full  output  1  fifo_counter == FIFO_DEPTH.
- fifo_half  output  1  fifo_counter >= FIFO_DEPTH/2.
- fifo_high  output  1  fifo_counter >= high_watermark; high_watermark 0 forces 1.
- fifo_empty  output  1  fifo_counter == 0.
- overflow  output  1  sticky: a write was dropped.
- underflow  output  1  sticky: a read was attempted while empty.
- drop_count  output  DROP_CNT_BITS  number of dropped writes; saturates at all-ones.

Behaviour:
- Reset: when reset_n is low at a clk edge, the following clear:
  - write/read pointers, fifo_counter, overflow, underflow, drop_count, test sequence counter
  - outputs after that edge: fifo_empty=1, fifo_full=0, fifo_half=0, fifo_high=(high_watermark==0), data_out=0
  - memory contents are not reset.
  - Reset has priority over all other inputs and aborts any in-progress operation with no partial write.
- All flags and fifo_counter are derived from registered counter state; they update in the cycle after the accepting edge.
- Write accepted when write_n=0 and either:
  - the FIFO is not full, or
  - the FIFO is full and a read is accepted in the same cycle.
- Write to a full FIFO without a simultaneous read:
  - word discarded, pointers and counter unchanged
  - overflow set, drop_count incremented (saturating).
- Read accepted when read_n=0 and the FIFO is not empty:
  - head word is presented on data_out before the edge (FWFT, zero latency)
  - the pop advances the read pointer; the next word appears after the edge.
- Read on an empty FIFO: underflow set; no pointer change.
- Empty FIFO with simultaneous read and write:
  - write accepted, read rejected, underflow set
  - word appears on data_out next cycle (write-to-data_out latency is 1 cycle).
- Counter update: +1 for write only, -1 for read only, unchanged when both are accepted.
- Pointers wrap modulo FIFO_DEPTH.
- clear_flags=1 clears overflow, underflow and drop_count.
  - If a drop occurs in the same cycle, the result is overflow=1 and drop_count=1 (new event wins).
- fifo_counter never exceeds FIFO_DEPTH.
- No combinational path from read_n or write_n to any output.

Optional Feature:
- Macro: FIFO_TEST_PATTERN_EN.
- Defined:
  - when test_mode=1, accepted write data is replaced by the test word:
    - bits [7:0] = chip_id
    - bits [39:8] = timestamp_32b
    - bits [55:40] = 16-bit sequence counter
    - bits above 55 = 0
  - sequence counter increments on each accepted test-mode write and wraps 0xFFFF->0; dropped writes do not increment it.
  - test_mode=0 stores data_in unchanged.
- Undefined: test_mode, chip_id and timestamp_32b are ignored (ports remain); no sequence counter is synthesised.

Test Plan:
- Bench configuration: FIFO_DEPTH=8, FIFO_BITS=3, FIFO_WIDTH=63, high_watermark=6.
- Reset then write 0x1..0x8 -> fifo_counter steps 1..8; fifo_half=1 at 4; fifo_high=1 at 6; fifo_full=1 at 8; data_out=0x1 from the cycle after the first write.
- Full FIFO, write 0x9 with read_n=1 -> overflow=1, drop_count=1, contents unchanged. Then read 8 words -> 0x1..0x8 in order, fifo_empty=1, data_out=0.
- Full FIFO, simultaneous write 0xA and read -> 0x1 popped, counter stays 8, no overflow. Drain -> 0x2..0x8, 0xA.
- Empty FIFO, simultaneous read and write 0x5 -> underflow=1, counter=1, data_out=0x5 next cycle. Then clear_flags=1 -> underflow=0, drop_count=0.
- Drive 20 writes past pointer wrap while popping every other cycle, then assert reset_n=0 mid-stream -> next cycle counter=0, fifo_empty=1, overflow=0; a subsequent write of 0x3 reads back 0x3.
- With FIFO_TEST_PATTERN_EN: test_mode=1, chip_id=0x2A, timestamp_32b=0x12345678, two writes -> words 0x0000_1234_5678_2A and 0x0001_1234_5678_2A (bits [55:0]).
